// File: rtl/reg_display_scanner.sv
// Four-digit multiplexed hex viewer for the core's R0/R1 debug taps.
// Pages through {R1, R0} 16 bits at a time from a snapshot that only changes on page boundaries.
module reg_display_scanner #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int PAGE_SCANS     = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] R0,
    input  logic [31:0] R1,
    input  logic        hold,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SC_W = (PAGE_SCANS > 1) ? $clog2(PAGE_SCANS) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(PAGE_SCANS - 1);

    logic [RC_W-1:0] rc;
    logic [1:0]      di;
    logic [SC_W-1:0] sc;
    logic [1:0]      page;
    logic [63:0]     snap;

    logic        slot_tick;
    logic        scan_tick;
    logic        page_event;
    logic        blank;
    logic [15:0] pd;
    logic [3:0]  nibble;
    logic [6:0]  glyph;
    logic [3:0]  an_next;

    assign slot_tick  = (rc == RC_LAST);
    assign scan_tick  = slot_tick && (di == 2'd3);
    assign page_event = scan_tick && (sc == SC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc   <= '0;
            di   <= 2'd0;
            sc   <= '0;
            page <= 2'd0;
            snap <= 64'd0;
        end else begin
            rc <= slot_tick ? '0 : rc + 1'b1;
            if (slot_tick) begin
                di <= di + 2'd1;
            end
            // sc wraps on every page event even while hold freezes the page
            if (scan_tick) begin
                sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
            end
            if (page_event && !hold) begin
                page <= page + 2'd1;
                snap <= {R1, R0};
            end
        end
    end

    // Anti-ghosting window at the start of each slot; absent entirely when BLANK_CYCLES is 0
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (rc < RC_W'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        pd = snap[15:0];
        case (page)
            2'd0: pd = snap[15:0];
            2'd1: pd = snap[31:16];
            2'd2: pd = snap[47:32];
            2'd3: pd = snap[63:48];
            default: pd = snap[15:0];
        endcase
    end

    assign nibble = pd[4*di +: 4];

    always_comb begin
        glyph = 7'b1111111;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'b1111111;
        endcase
    end

    assign an_next = ~(4'b0001 << di);

    // Pin-facing registers: everything the display sees is one cycle behind the counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (blank) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= glyph;
            dp  <= (di != page);
        end
    end

endmodule
